// File: rtl/or_arb_pkg.sv
// Shared types and helpers for the round-robin OR arbiter.
// rr_pick works on a fixed MAX_REQ-wide view so any requester count up to 16 can share it.
package or_arb_pkg;

    localparam int MAX_REQ  = 16;
    localparam int MAX_ID_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic                found;
        logic [MAX_ID_W-1:0] idx;
    } pick_t;

    // Scan from (last+1) mod n_req upward, wrapping at n_req so unused codes are never visited.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0]  req,
                                      input logic [MAX_ID_W-1:0] last,
                                      input logic [MAX_ID_W:0]   n_req);
        pick_t                r;
        logic [MAX_ID_W:0]    start;
        logic [MAX_ID_W:0]    pos;
        r     = '0;
        start = {1'b0, last} + 1'b1;
        if (start >= n_req) begin
            start = '0;
        end
        for (int k = 0; k < MAX_REQ; k++) begin
            pos = start + k[MAX_ID_W:0];
            if (pos >= n_req) begin
                pos = pos - n_req;
            end
            if (!r.found && (k < int'(n_req)) && req[pos[MAX_ID_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = pos[MAX_ID_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/or_unit_rr_arbiter_rr_priority_pick.sv
// Combinational round-robin winner selection: rotate past the last winner,
// priority-encode, rotate back to an absolute requester index.
module rr_priority_pick
    import or_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic             found,
    output logic [ID_W-1:0]  idx
);

    logic [MAX_REQ-1:0]  req_ext;
    logic [MAX_ID_W-1:0] last_ext;
    pick_t               pick;

    always_comb begin
        req_ext               = '0;
        req_ext[N_REQ-1:0]    = req;
        last_ext              = '0;
        last_ext[ID_W-1:0]    = last;
        pick                  = rr_pick(req_ext, last_ext, (MAX_ID_W+1)'(N_REQ));
    end

    assign found = pick.found;
    assign idx   = pick.idx[ID_W-1:0];

    // Upper index bits are always zero when fewer than MAX_REQ requesters exist.
    logic unused_idx_hi;
    assign unused_idx_hi = &{1'b0, pick.idx};

endmodule

// File: rtl/or_unit_rr_arbiter.sv
// Round-robin arbiter sharing one registered a|b unit among N_REQ requesters.
// valid/ready: a result transfers on any rising edge where out_valid && out_ready are both high.
module or_unit_rr_arbiter
    import or_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] a_in,
    input  logic [N_REQ*WIDTH-1:0] b_in,
    output logic [N_REQ-1:0]       gnt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [ID_W-1:0]        out_id
);

    arb_state_t       state;
    logic [ID_W-1:0]  last;
    logic             pick_found;
    logic [ID_W-1:0]  pick_idx;
    logic [WIDTH-1:0] or_vec [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_or
        assign or_vec[i] = a_in[i*WIDTH +: WIDTH] | b_in[i*WIDTH +: WIDTH];
    end

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req   (req),
        .last  (last),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            last      <= ID_W'(N_REQ-1);
            gnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else begin
            gnt <= '0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        out_data  <= or_vec[pick_idx];
                        out_id    <= pick_idx;
                        out_valid <= 1'b1;
                        gnt       <= N_REQ'(1) << pick_idx;
                        last      <= pick_idx;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    // req is ignored here, so a requester's stale req after its gnt is harmless.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
